// File: rtl/data_types_pkg.sv
// Shared types for the UART transmit arbiter: control register layout,
// its reset value, the arbiter FSM state encoding and a round-robin helper.
package data_types_pkg;

  typedef struct packed {
    logic [8:0] br_div;
    logic       word;
    logic       stop;
    logic       en;
  } ctrl_reg_t;

  localparam ctrl_reg_t CTRL_RST = '{br_div: 9'd8, word: 1'b0, stop: 1'b0, en: 1'b0};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } tx_arb_state_e;

  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first valid requester at or after ptr_i,
// wrapping past NREQ-1.
module rr_picker
  import data_types_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            found_o,
  output logic [IDW-1:0]  idx_o
);

  logic [IDW-1:0] cand [NREQ];

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      cand[k] = IDW'(rr_wrap(int'(ptr_i) + k, NREQ));
    end
  end

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_o && valid_i[cand[k]]) begin
        found_o = 1'b1;
        idx_o   = cand[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding frames from NREQ requesters into one uart_tx,
// with a shadowed control register applied only between frames.
module uart_tx_arb
  import data_types_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0][8:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  ctrl_reg_t            ctrl_in,
  input  logic                 ctrl_we,
  input  logic                 tx_idle,
  output logic                 tx_start,
  output logic [8:0]           tx_data,
  output ctrl_reg_t            tx_control,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic [15:0]          frame_cnt
);

  // state       | meaning
  // S_IDLE      | apply pending control, else grant a requester
  // S_START     | raise tx_start
  // S_WAIT_ACK  | hold tx_start until uart_tx leaves idle
  // S_WAIT_DONE | wait for uart_tx to return idle, count the frame

  tx_arb_state_e   state_q;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] req_ready_q;
  logic            tx_start_q;
  logic [8:0]      tx_data_q, tx_data_d;
  ctrl_reg_t       tx_control_q, shadow_q;
  logic            pending_q;
  logic [IDW-1:0]  grant_id_q;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic            pick_found;
  logic [IDW-1:0]  pick_idx;

  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_rr_picker (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    rr_ptr_d    = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
    frame_cnt_d = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
    tx_data_d   = tx_control_q.word ? req_data[pick_idx] : {1'b0, req_data[pick_idx][7:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      req_ready_q  <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_control_q <= CTRL_RST;
      shadow_q     <= CTRL_RST;
      pending_q    <= 1'b0;
      grant_id_q   <= '0;
      frame_cnt_q  <= '0;
    end else begin
      req_ready_q <= '0;
      case (state_q)
        S_IDLE: begin
          tx_start_q <= 1'b0;
          if (pending_q) begin
            tx_control_q <= shadow_q;
            pending_q    <= 1'b0;
          end else if (tx_control_q.en && pick_found) begin
            req_ready_q[pick_idx] <= 1'b1;
            tx_data_q             <= tx_data_d;
            grant_id_q            <= pick_idx;
            rr_ptr_q              <= rr_ptr_d;
            state_q               <= S_START;
          end
        end
        S_START: begin
          tx_start_q <= 1'b1;
          state_q    <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (!tx_idle) begin
            tx_start_q <= 1'b0;
            state_q    <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          tx_start_q <= 1'b0;
          if (tx_idle) begin
            frame_cnt_q <= frame_cnt_d;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A write always lands in the shadow; an apply in this same cycle uses the old shadow.
      if (ctrl_we) begin
        shadow_q  <= ctrl_in;
        pending_q <= 1'b1;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign tx_control = tx_control_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_id_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a small behavioural uart_tx idle model.
module tb_uart_tx_arb;
  import data_types_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req_valid = '0;
  logic [3:0][8:0] req_data = '0;
  logic [3:0]      req_ready;
  ctrl_reg_t       ctrl_in = CTRL_RST;
  logic            ctrl_we = 1'b0;
  logic            tx_idle = 1'b1;
  logic            tx_start;
  logic [8:0]      tx_data;
  ctrl_reg_t       tx_control;
  logic            busy;
  logic [1:0]      grant_id;
  logic [15:0]     frame_cnt;

  int n_chk = 0;
  int n_err = 0;
  int n_pulse = 0;
  int n_start_hi = 0;
  int grant_log[$];
  int tx_cnt = 0;

  uart_tx_arb #(.NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ctrl_in(ctrl_in), .ctrl_we(ctrl_we),
    .tx_idle(tx_idle), .tx_start(tx_start), .tx_data(tx_data),
    .tx_control(tx_control), .busy(busy), .grant_id(grant_id),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: leaves idle when it sees start, stays busy a few cycles.
  always @(negedge clk) begin
    if (rst) begin
      tx_idle = 1'b1;
      tx_cnt  = 0;
    end else if (tx_idle && tx_start) begin
      tx_idle = 1'b0;
      tx_cnt  = 6;
    end else if (!tx_idle) begin
      if (tx_cnt == 0) tx_idle = 1'b1;
      else tx_cnt = tx_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (req_ready != 0) begin
      n_pulse++;
      for (int i = 0; i < 4; i++) if (req_ready[i]) grant_log.push_back(i);
    end
    if (tx_start) n_start_hi++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_ctrl(input logic [11:0] c);
    ctrl_in = ctrl_reg_t'(c);
    ctrl_we = 1'b1;
    tick();
    ctrl_we = 1'b0;
  endtask

  task automatic wait_ready(output int idx);
    int base;
    int k;
    base = n_pulse;
    k = 0;
    while (n_pulse == base && k < 60) begin
      tick();
      k++;
    end
    if (n_pulse == base) begin
      chk("ready_timeout", 32'd0, 32'd1);
      idx = -1;
    end else begin
      idx = grant_log[$];
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    tick();
    while (busy && k < 200) begin
      tick();
      k++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_frame(input int idx, input logic [8:0] d, output logic [8:0] seen);
    int g;
    req_data[idx]  = d;
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    wait_ready(g);
    req_valid = '0;
    chk("frame_grant_idx", 32'(g), 32'(idx));
    tick();
    chk("frame_tx_start", 32'(tx_start), 32'd1);
    seen = tx_data;
    wait_idle();
  endtask

  initial begin
    int g;
    int base_p;
    int base_s;
    logic [8:0] seen;

    // reset state
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_control", 32'(tx_control), 32'h040);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);

    // single frame from requester 2, latency check
    write_ctrl(12'h041);
    tick();
    chk("t1_ctrl_applied", 32'(tx_control), 32'h041);
    req_data[2] = 9'h08E;
    req_valid   = 4'b0100;
    base_p      = n_pulse;
    tick();
    chk("t1_ready", 32'(req_ready), 32'b0100);
    chk("t1_start_not_yet", 32'(tx_start), 32'd0);
    req_valid = '0;
    tick();
    chk("t1_start_2cyc", 32'(tx_start), 32'd1);
    chk("t1_tx_data", 32'(tx_data), 32'h08E);
    wait_idle();
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_grant_id", 32'(grant_id), 32'd2);
    chk("t1_pulse_once", 32'(n_pulse - base_p), 32'd1);

    // all requesters valid: round-robin from 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    write_ctrl(12'h041);
    tick();
    grant_log.delete();
    for (int i = 0; i < 4; i++) req_data[i] = 9'(9'h010 + i);
    req_valid = 4'hF;
    for (int k = 0; k < 200 && grant_log.size() < 5; k++) tick();
    req_valid = '0;
    wait_idle();
    chk("t2_grant_count", 32'(grant_log.size()), 32'd5);
    if (grant_log.size() == 5) begin
      chk("t2_order0", 32'(grant_log[0]), 32'd0);
      chk("t2_order1", 32'(grant_log[1]), 32'd1);
      chk("t2_order2", 32'(grant_log[2]), 32'd2);
      chk("t2_order3", 32'(grant_log[3]), 32'd3);
      chk("t2_order4", 32'(grant_log[4]), 32'd0);
    end
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd5);

    // 9-bit data masking by word mode
    run_frame(1, 9'h1FE, seen);
    chk("t3_word0_data", 32'(seen), 32'h0FE);
    write_ctrl(12'h045);
    tick();
    run_frame(1, 9'h1FE, seen);
    chk("t3_word1_data", 32'(seen), 32'h1FE);

    // control write during S_WAIT_DONE is deferred to idle
    req_data[3] = 9'h0A5;
    req_valid   = 4'b1000;
    wait_ready(g);
    req_valid = '0;
    tick();
    tick();
    chk("t4_in_wait_done", 32'({busy, tx_start}), 32'b10);
    write_ctrl(12'h047);
    chk("t4_ctrl_held", 32'(tx_control), 32'h045);
    wait_idle();
    chk("t4_ctrl_held_idle", 32'(tx_control), 32'h045);
    req_data[3] = 9'h033;
    req_valid   = 4'b1000;
    base_p      = n_pulse;
    tick();
    chk("t4_ctrl_applied", 32'(tx_control), 32'h047);
    chk("t4_no_grant_on_apply", 32'(n_pulse - base_p), 32'd0);
    tick();
    chk("t4_grant_next", 32'(req_ready), 32'b1000);
    req_valid = '0;
    tick();
    chk("t4_start", 32'(tx_start), 32'd1);
    chk("t4_stop_bit", 32'(tx_control.stop), 32'd1);
    wait_idle();

    // en=0 blocks grants; re-enable grants requester 1
    write_ctrl(12'h046);
    tick();
    chk("t5_ctrl_en0", 32'(tx_control), 32'h046);
    req_valid = 4'b0010;
    base_p    = n_pulse;
    base_s    = n_start_hi;
    ticks(100);
    chk("t5_no_ready", 32'(n_pulse - base_p), 32'd0);
    chk("t5_no_start", 32'(n_start_hi - base_s), 32'd0);
    write_ctrl(12'h047);
    wait_ready(g);
    req_valid = '0;
    chk("t5_grant1", 32'(g), 32'd1);
    wait_idle();
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd10);

    // reset in S_WAIT_DONE
    req_data[0] = 9'h055;
    req_valid   = 4'b0001;
    wait_ready(g);
    req_valid = '0;
    tick();
    tick();
    chk("t6_in_wait_done", 32'({busy, tx_start}), 32'b10);
    rst = 1'b1;
    tick();
    chk("t6_tx_start", 32'(tx_start), 32'd0);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_tx_control", 32'(tx_control), 32'h040);
    chk("t6_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    ticks(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
